// File: rtl/fetch_unit.sv
// Purpose : instruction-fetch stage; owns the PC, addresses a combinational ROM and
//           registers the fetched word into an IF/ID output slot for decode.
// Latency : 1 cycle fetch-to-output; 2 edges from a redirect to the first new-target word.
// Backpressure: out_ready low with out_valid high freezes pc and the output slot.
// Ports:
//   clk, rst_n                      clock / async active-low reset
//   imem_addr, imem_instr           ROM address (= pc) and combinational read data
//   redirect_valid, redirect_target PC change request from execute
//   out_valid/out_ready             handshake with decode; out_instr/out_pc/out_pc_plus4 payload
//   halted, misalign_err            status (misalign_err is sticky)
//   fetch_count                     number of accepted handshakes, wraps at 2^CNT_W
module fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter bit          HALT_ON_ZERO = 1'b1,
  parameter int          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_instr,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_target,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_pc_plus4,
  output logic             halted,
  output logic             misalign_err,
  output logic [CNT_W-1:0] fetch_count
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  logic [31:0] pc;
  logic [1:0]  state;
  logic        accept;
  logic        advance;
  logic        redirect;
  logic        zero_word;

  assign imem_addr    = pc;
  assign out_pc_plus4 = out_pc + 32'd4;
  assign halted       = (state == ST_HALT);

  assign accept    = out_valid && out_ready;
  assign advance   = (state == ST_RUN) && (!out_valid || out_ready);
  // BOOT never fetches, so a redirect arriving there is simply dropped.
  assign redirect  = redirect_valid && (state != ST_BOOT);
  assign zero_word = HALT_ON_ZERO && (imem_instr == 32'h0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= RESET_PC;
      state        <= ST_BOOT;
      out_valid    <= 1'b0;
      out_instr    <= 32'h0;
      out_pc       <= 32'h0;
      misalign_err <= 1'b0;
      fetch_count  <= '0;
    end else begin
      // A handshake completing on the same edge as a redirect still counts.
      if (accept) begin
        fetch_count <= fetch_count + CNT_W'(1);
      end

      if (state == ST_BOOT) begin
        state <= ST_RUN;
      end else if (redirect) begin
        // Redirect wins over stall, fetch and halt; it flushes the held word.
        pc        <= {redirect_target[31:2], 2'b00};
        out_valid <= 1'b0;
        state     <= ST_RUN;
        if (redirect_target[1:0] != 2'b00) begin
          misalign_err <= 1'b1;
        end
      end else if (advance) begin
        out_instr <= imem_instr;
        out_pc    <= pc;
        out_valid <= 1'b1;
        pc        <= pc + 32'd4;
        if (zero_word) begin
          state <= ST_HALT;
        end
      end else if ((state == ST_HALT) && accept) begin
        // The zero word stays visible until decode takes it, then the slot empties.
        out_valid <= 1'b0;
      end
    end
  end

endmodule
